seq_stim_gen: RTL

Synthesizable stimulus transmitter for the sequence-detector input interface. It drives IN_VALID / MODE / DATA_IN, the same interface the detector receives on, so the detector can be exercised on-chip and in regression without a behavioural CPU model. One frame is built from LFSR pseudo-random filler nibbles interleaved with a programmable 4-nibble target pattern. It reports how many patterns it injected, which is the detector's expected hit count.

---
 rtl/seq_stim_pkg.sv | 29 ++
 rtl/seq_stim_gen_if.sv | 31 +++
 rtl/seq_lfsr8.sv | 28 ++
 rtl/seq_stim_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/seq_stim_pkg.sv
// Shared types and constants for the sequence-detector stimulus generator:
// FSM state encoding, filler LFSR tap mask and pattern nibble selection.
package seq_stim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAT  = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting register: bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;
    localparam logic [7:0] SEED_ZERO_SUB = 8'h01;

    localparam logic [1:0] NIB_FIRST = 2'd0;
    localparam logic [1:0] NIB_LAST  = 2'd3;

    function automatic logic [3:0] pat_nibble(input logic [15:0] pattern,
                                              input logic [1:0]  idx);
        case (idx)
            2'd0:    return pattern[15:12];
            2'd1:    return pattern[11:8];
            2'd2:    return pattern[7:4];
            default: return pattern[3:0];
        endcase
    endfunction

endpackage

// File: rtl/seq_stim_gen_if.sv
// Configuration/control inputs and detector-facing stream outputs of the
// stimulus generator; master is the generator, slave is whoever drives it.
interface seq_stim_gen_if #(
    parameter int LFSR_W = 8,
    parameter int FILL_W = 8
);
    logic              START;
    logic [1:0]        CFG_MODE;
    logic [15:0]       PATTERN;
    logic [FILL_W-1:0] FILL_LEN;
    logic [3:0]        REPEAT;
    logic [LFSR_W-1:0] SEED;
    logic              PAUSE;

    logic              BUSY;
    logic              DONE;
    logic              IN_VALID;
    logic [1:0]        MODE;
    logic [3:0]        DATA_IN;
    logic [3:0]        INJ_CNT;

    modport master (
        input  START, CFG_MODE, PATTERN, FILL_LEN, REPEAT, SEED, PAUSE,
        output BUSY, DONE, IN_VALID, MODE, DATA_IN, INJ_CNT
    );

    modport slave (
        output START, CFG_MODE, PATTERN, FILL_LEN, REPEAT, SEED, PAUSE,
        input  BUSY, DONE, IN_VALID, MODE, DATA_IN, INJ_CNT
    );
endinterface

// File: rtl/seq_lfsr8.sv
// 8-bit Fibonacci LFSR producing filler nibbles; load wins over advance,
// and a zero seed is replaced so the register can never lock up.
module seq_lfsr8
    import seq_stim_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] seed,
    output logic [3:0] nibble
);

    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= SEED_ZERO_SUB;
        end else if (load) begin
            lfsr <= (seed == 8'h00) ? SEED_ZERO_SUB : seed;
        end else if (advance) begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign nibble = lfsr[3:0];

endmodule

// File: rtl/seq_stim_gen.sv
// Frame generator: (filler, pattern) x REPEAT followed by a trailing filler
// segment, presented on the detector input interface with registered outputs.
module seq_stim_gen
    import seq_stim_pkg::*;
#(
    parameter int LFSR_W = 8,
    parameter int FILL_W = 8
) (
    input  logic          SYSCLK,
    input  logic          RST_B,
    seq_stim_gen_if.master bus
);

    state_t            state_q, state_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [FILL_W-1:0] fill_len_q, fill_len_d;
    logic [3:0]        rep_left_q, rep_left_d;
    logic [1:0]        nib_idx_q, nib_idx_d;
    logic [15:0]       pattern_q, pattern_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        data_q, data_d;
    logic [3:0]        inj_q, inj_d;

    logic              lfsr_load;
    logic              lfsr_adv;
    logic [3:0]        lfsr_nib;
    logic [LFSR_W-1:0] seed_in;

    assign seed_in = bus.SEED;

    seq_lfsr8 u_lfsr (
        .clk     (SYSCLK),
        .rst_n   (RST_B),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .seed    (seed_in),
        .nibble  (lfsr_nib)
    );

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            fill_len_q <= '0;
            rep_left_q <= '0;
            nib_idx_q  <= NIB_FIRST;
            pattern_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            mode_q     <= '0;
            data_q     <= '0;
            inj_q      <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            fill_len_q <= fill_len_d;
            rep_left_q <= rep_left_d;
            nib_idx_q  <= nib_idx_d;
            pattern_q  <= pattern_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            valid_q    <= valid_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            inj_q      <= inj_d;
        end
    end

    // PAUSE simply skips the emission branch, so every counter and the LFSR hold
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        fill_len_d = fill_len_q;
        rep_left_d = rep_left_q;
        nib_idx_d  = nib_idx_q;
        pattern_d  = pattern_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        valid_d    = 1'b0;
        mode_d     = mode_q;
        data_d     = data_q;
        inj_d      = inj_q;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    lfsr_load  = 1'b1;
                    fill_len_d = bus.FILL_LEN;
                    rep_left_d = bus.REPEAT;
                    pattern_d  = bus.PATTERN;
                    mode_d     = bus.CFG_MODE;
                    busy_d     = 1'b1;
                    inj_d      = '0;
                    fill_cnt_d = '0;
                    nib_idx_d  = NIB_FIRST;
                    if (bus.FILL_LEN != '0) begin
                        state_d = FILL;
                    end else if (bus.REPEAT != 4'd0) begin
                        state_d = PAT;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FILL: begin
                if (!bus.PAUSE) begin
                    valid_d  = 1'b1;
                    data_d   = lfsr_nib;
                    lfsr_adv = 1'b1;
                    if (fill_cnt_q == fill_len_q - FILL_W'(1)) begin
                        fill_cnt_d = '0;
                        nib_idx_d  = NIB_FIRST;
                        state_d    = (rep_left_q != 4'd0) ? PAT : FIN;
                    end else begin
                        fill_cnt_d = fill_cnt_q + FILL_W'(1);
                    end
                end
            end
            PAT: begin
                if (!bus.PAUSE) begin
                    valid_d   = 1'b1;
                    data_d    = pat_nibble(pattern_q, nib_idx_q);
                    nib_idx_d = nib_idx_q + 2'd1;
                    if (nib_idx_q == NIB_LAST) begin
                        inj_d      = inj_q + 4'd1;
                        rep_left_d = rep_left_q - 4'd1;
                        if (fill_len_q != '0) begin
                            state_d = FILL;
                        end else if (rep_left_q != 4'd1) begin
                            state_d = PAT;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.IN_VALID = valid_q;
    assign bus.MODE     = mode_q;
    assign bus.DATA_IN  = data_q;
    assign bus.INJ_CNT  = inj_q;

endmodule
